// File: rtl/ram_rr_arbiter_if.sv
// Requester-side and RAM port-B signals of the round-robin RAM arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface ram_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         ram_addr;
  logic                      ram_wren;
  logic                      ram_rden;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;

  modport slave (
    input  req, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_addr, ram_wren, ram_rden, ram_wdata
  );

  modport master (
    output req, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_addr, ram_wren, ram_rden, ram_wdata
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing RAM port B among NUM_REQ requesters.
// Define RAM_ARB_OUTREG_EN to register the RAM command (adds one cycle of read latency).
//
// state     | meaning
// ST_OPEN   | normal round-robin search starting at r_ptr
// ST_LOCKED | r_owner holds the port; only it may be granted
module ram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  ram_rr_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   w_win;
  logic               w_found;
  logic               w_grant;
  logic [ADDR_W-1:0]  w_cmd_addr;
  logic [DATA_W-1:0]  w_cmd_wdata;
  logic               w_cmd_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_v1;
  logic [PTR_W-1:0]   r_id1;
  logic               w_rv;
  logic [PTR_W-1:0]   w_rid;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] v);
    f_inc = (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    if (r_state == ST_LOCKED) begin
      w_found = bus.req[r_owner];
      w_win   = r_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_found && bus.req[PTR_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
          w_found = 1'b1;
          w_win   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
        end
      end
    end
    w_grant = w_found & ~i_reset;
  end

  always_comb begin
    bus.gnt = '0;
    if (w_grant) bus.gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_OPEN: begin
        if (w_grant) begin
          if (bus.req_lock[w_win]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_win;
            w_ptr_nxt   = w_win;
          end else begin
            w_ptr_nxt = f_inc(w_win);
          end
        end
      end
      ST_LOCKED: begin
        // owner either finished the burst or walked away; both release
        if (!bus.req[r_owner] || !bus.req_lock[r_owner]) begin
          w_state_nxt = ST_OPEN;
          w_ptr_nxt   = f_inc(r_owner);
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_OPEN;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign w_cmd_addr  = bus.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_cmd_wdata = bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
  assign w_cmd_we    = bus.req_we[w_win];

  // address/data keep the last granted command so the RAM output stays put when idle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_addr  <= w_cmd_addr;
      r_wdata <= w_cmd_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_v1  <= 1'b0;
      r_id1 <= '0;
    end else begin
      r_v1  <= w_grant & ~w_cmd_we;
      r_id1 <= w_win;
    end
  end

`ifdef RAM_ARB_OUTREG_EN
  logic             r_wren;
  logic             r_rden;
  logic             r_v2;
  logic [PTR_W-1:0] r_id2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wren <= 1'b0;
      r_rden <= 1'b0;
      r_v2   <= 1'b0;
      r_id2  <= '0;
    end else begin
      r_wren <= w_grant & w_cmd_we;
      r_rden <= w_grant & ~w_cmd_we;
      r_v2   <= r_v1;
      r_id2  <= r_id1;
    end
  end

  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_wren  = r_wren;
  assign bus.ram_rden  = r_rden;
  assign w_rv          = r_v2;
  assign w_rid         = r_id2;
`else
  assign bus.ram_addr  = w_grant ? w_cmd_addr : r_addr;
  assign bus.ram_wdata = w_grant ? w_cmd_wdata : r_wdata;
  assign bus.ram_wren  = w_grant & w_cmd_we;
  assign bus.ram_rden  = w_grant & ~w_cmd_we;
  assign w_rv          = r_v1;
  assign w_rid         = r_id1;
`endif

  always_comb begin
    bus.rvalid = '0;
    if (w_rv) bus.rvalid[w_rid] = 1'b1;
  end

  assign bus.rdata = bus.ram_rdata;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural 1024x32 port-B RAM model.
// A background monitor checks every cycle's rvalid/rdata against expected read returns.
module tb_ram_rr_arbiter;
`ifdef RAM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];
  logic [31:0] mem [1024];
  logic [3:0]  rr_exp [5];

  ram_rr_arbiter_if #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32)) ifc ();

  ram_rr_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifc.ram_wren) mem[ifc.ram_addr] <= ifc.ram_wdata;
    if (ifc.ram_rden) ifc.ram_rdata <= mem[ifc.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rvalid", 32'(ifc.rvalid), 32'(1) << exp_q[0].id);
      chk("rdata", ifc.rdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      chk("rvalid_quiet", 32'(ifc.rvalid), 32'h0);
    end
  end

  task automatic clr();
    ifc.req      = '0;
    ifc.req_we   = '0;
    ifc.req_lock = '0;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    clr();
  endtask

  task automatic set_cmd(input int i, input bit we, input bit lock,
                         input logic [9:0] a, input logic [31:0] d);
    ifc.req[i]               = 1'b1;
    ifc.req_we[i]            = we;
    ifc.req_lock[i]          = lock;
    ifc.req_addr[i*10 +: 10] = a;
    ifc.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic all_rd(input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      if (mask[i]) set_cmd(i, 1'b0, 1'b0, 10'(i), 32'h0);
  endtask

  task automatic all_wr(input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      if (mask[i]) set_cmd(i, 1'b1, 1'b0, 10'(i), 32'h10 + 32'(i));
  endtask

  task automatic push(input int id, input logic [31:0] d);
    exp_t e;
    e.due  = cyc + LAT;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_gnt"}, 32'(ifc.gnt), 32'h0);
    chk({tag, "_wren"}, 32'(ifc.ram_wren), 32'h0);
    chk({tag, "_rden"}, 32'(ifc.ram_rden), 32'h0);
    chk({tag, "_addr"}, 32'(ifc.ram_addr), 32'h0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    reset   = 1'b1;
    clr();
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset held for three cycles, then idle
    repeat (3) begin
      cyc_begin();
      #1;
      chk_idle_pins("rst");
    end
    cyc_begin();
    reset = 1'b0;
    #1;
    chk_idle_pins("idle0");
    cyc_begin();
    #1;
    chk_idle_pins("idle1");

    // single write then read of 0x3FF
    cyc_begin();
    set_cmd(0, 1'b1, 1'b0, 10'h3FF, 32'hDEADBEEF);
    #1;
    chk("wr_gnt", 32'(ifc.gnt), 32'h1);
`ifndef RAM_ARB_OUTREG_EN
    chk("wr_wren", 32'(ifc.ram_wren), 32'h1);
    chk("wr_addr", 32'(ifc.ram_addr), 32'h3FF);
    chk("wr_wdata", ifc.ram_wdata, 32'hDEADBEEF);
`endif
    cyc_begin();
    set_cmd(0, 1'b0, 1'b0, 10'h3FF, 32'h0);
    #1;
    chk("rd_gnt", 32'(ifc.gnt), 32'h1);
    push(0, 32'hDEADBEEF);
`ifdef RAM_ARB_OUTREG_EN
    chk("wr_wren", 32'(ifc.ram_wren), 32'h1);
    chk("wr_addr", 32'(ifc.ram_addr), 32'h3FF);
    chk("wr_wdata", ifc.ram_wdata, 32'hDEADBEEF);
`else
    chk("rd_rden", 32'(ifc.ram_rden), 32'h1);
    chk("rd_wren", 32'(ifc.ram_wren), 32'h0);
`endif
    cyc_begin();
    #1;
    chk("hold_gnt", 32'(ifc.gnt), 32'h0);
    chk("hold_addr", 32'(ifc.ram_addr), 32'h3FF);
`ifdef RAM_ARB_OUTREG_EN
    chk("hold_rden", 32'(ifc.ram_rden), 32'h1);
`else
    chk("hold_rden", 32'(ifc.ram_rden), 32'h0);
`endif

    // preload addr i with 0x10+i; ptr starts at 1 here
    cyc_begin(); all_wr(4'b1111); #1; chk("pre_gnt1", 32'(ifc.gnt), 32'b0010);
    cyc_begin(); all_wr(4'b1101); #1; chk("pre_gnt2", 32'(ifc.gnt), 32'b0100);
    cyc_begin(); all_wr(4'b1001); #1; chk("pre_gnt3", 32'(ifc.gnt), 32'b1000);
    cyc_begin(); all_wr(4'b0001); #1; chk("pre_gnt0", 32'(ifc.gnt), 32'b0001);

    // pointer wrap: req 3 alone, then req 0 and 3 together
    cyc_begin(); all_rd(4'b1000); #1; chk("wrap_gnt3", 32'(ifc.gnt), 32'b1000); push(3, 32'h13);
    cyc_begin(); all_rd(4'b1001); #1; chk("wrap_gnt0", 32'(ifc.gnt), 32'b0001); push(0, 32'h10);
    cyc_begin(); all_rd(4'b1000); #1; chk("wrap_gnt3b", 32'(ifc.gnt), 32'b1000); push(3, 32'h13);

    // fairness from ptr 0 with all requesters reading
    for (int s = 0; s < 5; s++) begin
      cyc_begin();
      all_rd(4'b1111);
      #1;
      chk("rr_gnt", 32'(ifc.gnt), 32'(rr_exp[s]));
      push(s % 4, 32'h10 + 32'(s % 4));
    end

    cyc_begin(); all_rd(4'b0010); #1; chk("pre_lock_gnt", 32'(ifc.gnt), 32'b0010); push(1, 32'h11);

    // lock: req 2 bursts three locked reads then one unlocked
    for (int s = 0; s < 3; s++) begin
      cyc_begin();
      all_rd(4'b1111);
      ifc.req_lock[2] = 1'b1;
      #1;
      chk("lock_gnt", 32'(ifc.gnt), 32'b0100);
      push(2, 32'h12);
    end
    cyc_begin(); all_rd(4'b1111); #1; chk("unlock_gnt", 32'(ifc.gnt), 32'b0100); push(2, 32'h12);
    cyc_begin(); all_rd(4'b1111); #1; chk("after_lock_gnt", 32'(ifc.gnt), 32'b1000); push(3, 32'h13);

    // owner 0 locks, then drops req: one dead cycle, then ptr = 1
    cyc_begin(); all_rd(4'b1111); ifc.req_lock[0] = 1'b1; #1;
    chk("own_gnt", 32'(ifc.gnt), 32'b0001); push(0, 32'h10);
    cyc_begin(); all_rd(4'b1110); #1;
    chk("drop_gnt", 32'(ifc.gnt), 32'h0);
`ifndef RAM_ARB_OUTREG_EN
    chk("drop_rden", 32'(ifc.ram_rden), 32'h0);
`endif
    cyc_begin(); all_rd(4'b1110); #1; chk("rel_gnt", 32'(ifc.gnt), 32'b0010); push(1, 32'h11);

    repeat (3) begin
      cyc_begin();
      #1;
      chk("drain_gnt", 32'(ifc.gnt), 32'h0);
    end

    // reset right after a read grant discards that read
    cyc_begin(); all_rd(4'b0010); #1; chk("mid_gnt", 32'(ifc.gnt), 32'b0010);
    @(posedge clk);
    reset = 1'b1;
    exp_q.delete();
    cyc_begin(); all_rd(4'b0110); #1;
    chk("inrst_gnt", 32'(ifc.gnt), 32'h0);
    chk("inrst_rden", 32'(ifc.ram_rden), 32'h0);
    chk("inrst_addr", 32'(ifc.ram_addr), 32'h0);
    cyc_begin(); all_rd(4'b0110); #1;
    chk("inrst_gnt2", 32'(ifc.gnt), 32'h0);
    cyc_begin(); reset = 1'b0; all_rd(4'b0110); #1;
    chk("postrst_gnt", 32'(ifc.gnt), 32'b0010);
    push(1, 32'h11);

    repeat (4) cyc_begin();
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
